carry_look_ahead_adder: RTL and testbench

//   Registered WIDTH-bit carry-lookahead adder: o_Sum/o_Cout = i_A + i_B + i_Cin.
//   Two-level lookahead (4-bit CLA groups plus a group-level lookahead unit), so the

---
 rtl/carry_look_ahead_adder.sv | 159 +++++++++++++++
 tb/tb_carry_look_ahead_adder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/carry_look_ahead_adder.sv
// Registered WIDTH-bit two-level carry-lookahead adder: {o_Cout,o_Sum} = i_A + i_B + i_Cin.
// Optional build macro CLA_IN_REG_EN adds a reset-to-zero input register stage (latency 2).
module carry_look_ahead_adder #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_A,
  input  logic [WIDTH-1:0] i_B,
  input  logic             i_Cin,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_Sum,
  output logic             o_Cout
);

  localparam int NG = (WIDTH + 3) / 4;
  localparam int PW = NG * 4;

  // Carries into bits 0..3 of a 4-bit group, each written as a flat sum of products.
  function automatic logic [3:0] group_carries(input logic [2:0] g, input logic [2:0] p,
                                               input logic cin);
    logic [3:0] c;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    return c;
  endfunction

  function automatic logic group_generate(input logic [3:0] g, input logic [3:1] p);
    return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  endfunction

  logic [WIDTH-1:0] op_a_s;
  logic [WIDTH-1:0] op_b_s;
  logic             op_cin_s;
  logic             op_valid_s;

`ifdef CLA_IN_REG_EN
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             cin_r;
  logic             valid_in_r;

  // Input capture stage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      a_r        <= '0;
      b_r        <= '0;
      cin_r      <= 1'b0;
      valid_in_r <= 1'b0;
    end else begin
      a_r        <= i_A;
      b_r        <= i_B;
      cin_r      <= i_Cin;
      valid_in_r <= i_valid;
    end
  end

  assign op_a_s     = a_r;
  assign op_b_s     = b_r;
  assign op_cin_s   = cin_r;
  assign op_valid_s = valid_in_r;
`else
  assign op_a_s     = i_A;
  assign op_b_s     = i_B;
  assign op_cin_s   = i_Cin;
  assign op_valid_s = i_valid;
`endif

  logic [PW-1:0]    a_ext_s;
  logic [PW-1:0]    b_ext_s;
  logic [PW-1:0]    g_s;
  logic [PW-1:0]    p_s;
  logic [NG-1:0]    gg_s;
  logic [NG-1:0]    gp_s;
  logic [NG:0]      gc_s;
  logic [PW:0]      c_s;
  logic [WIDTH-1:0] sum_s;

  // Padding bits are zero, so they neither generate nor propagate.
  assign a_ext_s = PW'(op_a_s);
  assign b_ext_s = PW'(op_b_s);
  assign g_s     = a_ext_s & b_ext_s;
  assign p_s     = a_ext_s ^ b_ext_s;

  // Group generate / propagate.
  always_comb begin
    gg_s = '0;
    gp_s = '0;
    for (int k = 0; k < NG; k++) begin
      gg_s[k] = group_generate(g_s[4*k +: 4], p_s[4*k+1 +: 3]);
      gp_s[k] = &p_s[4*k +: 4];
    end
  end

  // Lookahead unit: every group carry-in is an independent sum of products.
  always_comb begin
    logic carry_v;
    logic chain_v;
    gc_s    = '0;
    gc_s[0] = op_cin_s;
    for (int k = 0; k < NG; k++) begin
      carry_v = 1'b0;
      for (int j = 0; j <= k; j++) begin
        chain_v = gg_s[j];
        for (int m = j + 1; m <= k; m++) begin
          chain_v = chain_v & gp_s[m];
        end
        carry_v = carry_v | chain_v;
      end
      chain_v = op_cin_s;
      for (int m = 0; m <= k; m++) begin
        chain_v = chain_v & gp_s[m];
      end
      gc_s[k+1] = carry_v | chain_v;
    end
  end

  // Per-bit carries and sum.
  always_comb begin
    logic [3:0] grp_c_v;
    c_s = '0;
    for (int k = 0; k < NG; k++) begin
      grp_c_v       = group_carries(g_s[4*k +: 3], p_s[4*k +: 3], gc_s[k]);
      c_s[4*k +: 4] = grp_c_v;
    end
    c_s[PW] = gc_s[NG];
    sum_s   = p_s[WIDTH-1:0] ^ c_s[WIDTH-1:0];
  end

  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             valid_r;

  // Result register; the carry out is the carry into bit WIDTH, never a padding carry.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sum_r   <= '0;
      cout_r  <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      valid_r <= op_valid_s;
      if (op_valid_s) begin
        sum_r  <= sum_s;
        cout_r <= c_s[WIDTH];
      end else begin
        sum_r  <= sum_r;
        cout_r <= cout_r;
      end
    end
  end

  assign o_valid = valid_r;
  assign o_Sum   = sum_r;
  assign o_Cout  = cout_r;

endmodule

// File: tb/tb_carry_look_ahead_adder.sv
// Self-checking bench for carry_look_ahead_adder against an arithmetic + reference model.
// Honours the CLA_IN_REG_EN build macro for the expected latency.
module tb_carry_look_ahead_adder;

  parameter int WIDTH = 4;
`ifdef CLA_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct packed {
    logic           v;
    logic [WIDTH:0] res;
  } txn_t;

  logic             i_clk = 1'b0;
  logic             i_rst_n;
  logic             i_valid;
  logic [WIDTH-1:0] i_A;
  logic [WIDTH-1:0] i_B;
  logic             i_Cin;
  logic             o_valid;
  logic [WIDTH-1:0] o_Sum;
  logic             o_Cout;

  int errors = 0;
  int checks = 0;

  txn_t           pipe[$];
  logic [WIDTH:0] held;

  carry_look_ahead_adder #(.WIDTH(WIDTH)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_valid),
    .i_A     (i_A),
    .i_B     (i_B),
    .i_Cin   (i_Cin),
    .o_valid (o_valid),
    .o_Sum   (o_Sum),
    .o_Cout  (o_Cout)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic c);
    logic [WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
    return s;
  endfunction

  task automatic model_reset();
    txn_t bubble;
    bubble = '0;
    pipe.delete();
    for (int i = 0; i < LAT - 1; i++) pipe.push_back(bubble);
    held = '0;
  endtask

  // Apply one input beat, clock it, and compare the outputs with the model.
  task automatic step(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic c, input string tag);
    txn_t t;
    txn_t o;
    i_valid = v;
    i_A     = a;
    i_B     = b;
    i_Cin   = c;
    @(posedge i_clk);
    #1;
    t.v   = v;
    t.res = ref_add(a, b, c);
    pipe.push_back(t);
    o = pipe.pop_front();
    if (o.v) held = o.res;
    checks++;
    if (o_valid !== o.v) begin
      errors++;
      $display("FAIL %s o_valid: got %b expected %b (A=%h B=%h Cin=%b)", tag, o_valid, o.v, a, b, c);
    end
    checks++;
    if ({o_Cout, o_Sum} !== held) begin
      errors++;
      $display("FAIL %s sum: got %h expected %h (A=%h B=%h Cin=%b)", tag, {o_Cout, o_Sum}, held, a, b, c);
    end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_A     = '0;
    i_B     = '0;
    i_Cin   = 1'b0;
    model_reset();
    @(posedge i_clk);
    #1;
    checks++;
    if ({o_valid, o_Cout, o_Sum} !== '0) begin
      errors++;
      $display("FAIL reset_state: got valid=%b cout=%b sum=%h expected all zero", o_valid, o_Cout, o_Sum);
    end
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
  endtask

  task automatic test_exhaustive();
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++)
          step(1'b1, WIDTH'(a), WIDTH'(b), c[0], "exhaustive");
  endtask

  task automatic test_carry_chain();
    step(1'b1, {WIDTH{1'b1}}, '0, 1'b1, "carry_chain");
    step(1'b1, '0, {WIDTH{1'b1}}, 1'b1, "carry_chain_b");
    for (int i = 0; i < LAT; i++) step(1'b0, '0, '0, 1'b0, "carry_chain_drain");
  endtask

  task automatic test_wrap();
    step(1'b1, {WIDTH{1'b1}}, {WIDTH{1'b1}}, 1'b1, "wrap_max");
    step(1'b1, {WIDTH{1'b1}}, WIDTH'(1), 1'b0, "wrap_plus_one");
    for (int i = 0; i < LAT; i++) step(1'b0, '0, '0, 1'b0, "wrap_drain");
  endtask

  task automatic test_hold();
    logic [WIDTH:0] exp_v;
    exp_v = ref_add(WIDTH'(3), WIDTH'(4), 1'b0);
    step(1'b1, WIDTH'(3), WIDTH'(4), 1'b0, "hold_load");
    for (int i = 0; i < LAT + 2; i++)
      step(1'b0, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), "hold");
    checks++;
    if (o_Sum !== exp_v[WIDTH-1:0] || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_final: got sum=%h valid=%b expected sum=%h valid=0", o_Sum, o_valid,
               exp_v[WIDTH-1:0]);
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 3; i++)
      step(1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), "pre_reset");
    i_A   = {WIDTH{1'b1}};
    i_B   = {WIDTH{1'b1}};
    i_Cin = 1'b1;
    #2;
    i_rst_n = 1'b0;
    #1;
    checks++;
    if ({o_valid, o_Cout, o_Sum} !== '0) begin
      errors++;
      $display("FAIL mid_reset_async: got valid=%b cout=%b sum=%h expected all zero", o_valid, o_Cout, o_Sum);
    end
    @(posedge i_clk);
    #1;
    checks++;
    if ({o_valid, o_Cout, o_Sum} !== '0) begin
      errors++;
      $display("FAIL mid_reset_held: got valid=%b cout=%b sum=%h expected all zero", o_valid, o_Cout, o_Sum);
    end
    model_reset();
    i_rst_n = 1'b1;
    for (int i = 0; i < LAT + 2; i++)
      step(1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), "post_reset");
  endtask

  task automatic test_random();
    for (int i = 0; i < 10000; i++)
      step(($urandom_range(0, 9) < 8), WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), "random");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 32; i++)
      step(1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), "back_to_back");
  endtask

  initial begin
    test_reset();
    test_exhaustive();
    test_carry_chain();
    test_wrap();
    test_hold();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
